// File: rtl/uart_loader_if.sv
// Bus bundle for uart_loader: UART CSR initiator signals plus the memory write port.
// The loader drives through the master modport; the UART slave and memory sit on the slave modport.
interface uart_loader_if;
    logic        u_stb_o;
    logic        u_we_o;
    logic [31:0] u_adr_o;
    logic [31:0] u_dat_o;
    logic [31:0] u_dat_i;
    logic        u_ack_i;
    logic        m_stb_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_ack_i;

    modport master (
        output u_stb_o, u_we_o, u_adr_o, u_dat_o, m_stb_o, m_adr_o, m_dat_o,
        input  u_dat_i, u_ack_i, m_ack_i
    );

    modport slave (
        input  u_stb_o, u_we_o, u_adr_o, u_dat_o, m_stb_o, m_adr_o, m_dat_o,
        output u_dat_i, u_ack_i, m_ack_i
    );
endinterface

// File: rtl/uart_loader.sv
// Serial boot loader: polls the UART RX register for a little-endian word-count header
// and payload, writes each word to memory, then returns an 8-bit checksum over UART TX.
module uart_loader #(
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'd4096
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic [31:0]   base_addr,
    uart_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, MEM_WR, TX_REQ, TX_GAP, FIN
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] asm_reg, asm_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [31:0] word_idx_reg, word_idx_next;
    logic [31:0] count_reg, count_next;
    logic [7:0]  csum_reg, csum_next;
    logic        hdr_reg, hdr_next;
    logic        err_reg, err_next;

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] asm_merged;
    logic [31:0] word_idx_inc;
    logic        unused_dat;

    assign rx_byte      = bus.u_dat_i[7:0];
    assign rx_valid     = bus.u_dat_i[8];
    assign word_idx_inc = word_idx_reg + 32'd1;
    assign unused_dat   = ^bus.u_dat_i[31:9];

    // Incoming byte lands in the lane selected by the byte index (lane 0 = bits [7:0]).
    always_comb begin
        asm_merged = asm_reg;
        asm_merged[{byte_idx_reg, 3'b000} +: 8] = rx_byte;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            asm_reg      <= '0;
            byte_idx_reg <= '0;
            word_idx_reg <= '0;
            count_reg    <= '0;
            csum_reg     <= '0;
            hdr_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            asm_reg      <= asm_next;
            byte_idx_reg <= byte_idx_next;
            word_idx_reg <= word_idx_next;
            count_reg    <= count_next;
            csum_reg     <= csum_next;
            hdr_reg      <= hdr_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        asm_next      = asm_reg;
        byte_idx_next = byte_idx_reg;
        word_idx_next = word_idx_reg;
        count_next    = count_reg;
        csum_next     = csum_reg;
        hdr_next      = hdr_reg;
        err_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next     = base_addr;
                    byte_idx_next = '0;
                    word_idx_next = '0;
                    csum_next     = '0;
                    hdr_next      = 1'b1;
                    state_next    = RD_REQ;
                end
            end
            RD_REQ: state_next = RD_WAIT;
            RD_WAIT: begin
                state_next = RD_REQ;
                if (rx_valid) begin
                    asm_next      = asm_merged;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (hdr_reg) begin
                        // Full 32-bit count comparison so an all-ones header is rejected.
                        if (byte_idx_reg == 2'd3) begin
                            count_next = asm_merged;
                            hdr_next   = 1'b0;
                            if (asm_merged > MAX_WORDS) begin
                                err_next   = 1'b1;
                                state_next = IDLE;
                            end else if (asm_merged == '0) begin
                                state_next = TX_REQ;
                            end
                        end
                    end else begin
                        csum_next = csum_reg + rx_byte;
                        if (byte_idx_reg == 2'd3) begin
                            state_next = MEM_WR;
                        end
                    end
                end
            end
            MEM_WR: begin
                if (bus.m_ack_i) begin
                    addr_next     = addr_reg + 32'd4;
                    word_idx_next = word_idx_inc;
                    state_next    = (word_idx_inc == count_reg) ? TX_REQ : RD_REQ;
                end
            end
            TX_REQ: begin
                if (bus.u_ack_i) begin
                    state_next = TX_GAP;
                end
            end
            TX_GAP:  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign bus.u_stb_o = (state_reg == RD_REQ) || (state_reg == TX_REQ);
    assign bus.u_we_o  = (state_reg == TX_REQ);
    assign bus.u_adr_o = {UART_BASE[31:2], 2'b00};
    assign bus.u_dat_o = (state_reg == TX_REQ) ? {24'h0, csum_reg} : 32'h0;
    assign bus.m_stb_o = (state_reg == MEM_WR);
    assign bus.m_adr_o = (state_reg == MEM_WR) ? addr_reg : 32'h0;
    assign bus.m_dat_o = (state_reg == MEM_WR) ? asm_reg : 32'h0;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIN);
    assign err  = err_reg;
endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: UART/memory responder, scoreboard queues filled by the driver,
// and an independent monitor that checks every strobe, ack and done/err pulse.
`timescale 1ns/1ps
module tb_uart_loader;
    localparam logic [31:0] UART_BASE = 32'h8000_0010;
    localparam logic [31:0] MAX_WORDS = 32'd4;
    localparam logic [1:0]  EV_DONE   = 2'b10;
    localparam logic [1:0]  EV_ERR    = 2'b01;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;

    uart_loader_if bus();

    uart_loader #(.UART_BASE(UART_BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_wait = 0;
    int tx_wait = 0;
    int last_pop_cyc = 0;
    int last_mack_cyc = 0;
    int tx_acc_cyc = 0;

    logic [8:0]  rx_q[$];
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [1:0]  exp_evt_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic rx(input logic [7:0] b);
        rx_q.push_back({1'b1, b});
    endtask

    task automatic rx_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) rx(w[8*i +: 8]);
    endtask

    task automatic rx_idle(input int n);
        for (int i = 0; i < n; i++) rx_q.push_back(9'h0EE);
    endtask

    task automatic exp_mem(input logic [31:0] adr, input logic [31:0] dat);
        exp_adr_q.push_back(adr);
        exp_dat_q.push_back(dat);
    endtask

    task automatic launch(input logic [31:0] base);
        @(negedge sys_clk);
        base_addr = base;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic finish_image(input string name);
        int n;
        n = 0;
        while (exp_evt_q.size() != 0 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk({name, "_event_timeout"}, 32'(exp_evt_q.size()), 32'd0);
        repeat (2) @(negedge sys_clk);
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_mem_left"}, 32'(exp_adr_q.size()), 32'd0);
        chk({name, "_tx_left"}, 32'(exp_tx_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_u_stb"}, 32'(bus.u_stb_o), 32'd0);
        chk({name, "_u_we"},  32'(bus.u_we_o),  32'd0);
        chk({name, "_u_adr"}, bus.u_adr_o, UART_BASE);
        chk({name, "_u_dat"}, bus.u_dat_o, 32'd0);
        chk({name, "_m_stb"}, 32'(bus.m_stb_o), 32'd0);
        chk({name, "_m_adr"}, bus.m_adr_o, 32'd0);
        chk({name, "_m_dat"}, bus.m_dat_o, 32'd0);
        chk({name, "_busy"},  32'(busy), 32'd0);
        chk({name, "_done"},  32'(done), 32'd0);
        chk({name, "_err"},   32'(err),  32'd0);
    endtask

    // UART slave (registered RX data, pops on a read strobe) and ack responders.
    initial begin
        logic       prev_rd;
        logic [8:0] e;
        int         mcnt;
        int         tcnt;
        prev_rd = 1'b0;
        mcnt = 0;
        tcnt = 0;
        bus.u_dat_i = 32'h0;
        bus.u_ack_i = 1'b0;
        bus.m_ack_i = 1'b0;
        forever begin
            @(posedge sys_clk);
            cyc++;
            #1;
            if (prev_rd) begin
                e = 9'h000;
                if (rx_q.size() > 0) e = rx_q.pop_front();
                if (e[8]) last_pop_cyc = cyc;
                bus.u_dat_i = {23'h0, e};
            end
            prev_rd = bus.u_stb_o && !bus.u_we_o;
            if (bus.m_stb_o) begin
                if (mcnt < mem_wait) begin
                    bus.m_ack_i = 1'b0;
                    mcnt++;
                end else begin
                    bus.m_ack_i = 1'b1;
                end
            end else begin
                bus.m_ack_i = 1'b0;
                mcnt = 0;
            end
            if (bus.u_stb_o && bus.u_we_o) begin
                if (tcnt < tx_wait) begin
                    bus.u_ack_i = 1'b0;
                    tcnt++;
                end else begin
                    bus.u_ack_i = 1'b1;
                end
            end else begin
                bus.u_ack_i = bus.u_stb_o;
                tcnt = 0;
            end
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        logic       prev_rd;
        logic       prev_m;
        logic       prev_tx;
        logic       prev_evt;
        logic       rd;
        logic       txs;
        logic [1:0] ev;
        int         ref_cyc;
        prev_rd = 1'b0;
        prev_m = 1'b0;
        prev_tx = 1'b0;
        prev_evt = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_rd = 1'b0;
                prev_m = 1'b0;
                prev_tx = 1'b0;
                prev_evt = 1'b0;
                continue;
            end
            rd  = bus.u_stb_o && !bus.u_we_o;
            txs = bus.u_stb_o && bus.u_we_o;
            if (bus.u_stb_o) chk("u_adr", bus.u_adr_o, UART_BASE);
            if (rd) chk("rd_strobe_gap", 32'(prev_rd), 32'd0);

            if (bus.m_stb_o) begin
                if (!prev_m) chk("mem_latency", 32'(cyc), 32'(last_pop_cyc + 1));
                chk("mem_write_expected", 32'(exp_adr_q.size() != 0), 32'd1);
                if (exp_adr_q.size() != 0) begin
                    chk("mem_adr", bus.m_adr_o, exp_adr_q[0]);
                    chk("mem_dat", bus.m_dat_o, exp_dat_q[0]);
                    if (bus.m_ack_i) begin
                        void'(exp_adr_q.pop_front());
                        void'(exp_dat_q.pop_front());
                        last_mack_cyc = cyc;
                        $display("MEM write adr=%h dat=%h cyc=%0d", bus.m_adr_o, bus.m_dat_o, cyc);
                    end
                end
            end

            if (txs) begin
                if (!prev_tx) begin
                    ref_cyc = (last_mack_cyc > last_pop_cyc) ? last_mack_cyc : last_pop_cyc;
                    chk("tx_latency", 32'(cyc), 32'(ref_cyc + 1));
                end
                chk("tx_write_expected", 32'(exp_tx_q.size() != 0), 32'd1);
                if (exp_tx_q.size() != 0) begin
                    chk("tx_dat", bus.u_dat_o, {24'h0, exp_tx_q[0]});
                    if (bus.u_ack_i) begin
                        void'(exp_tx_q.pop_front());
                        tx_acc_cyc = cyc;
                        $display("TX  write dat=%h cyc=%0d", bus.u_dat_o, cyc);
                    end
                end
            end

            if (done || err) begin
                chk("event_width", 32'(prev_evt), 32'd0);
                chk("event_pending", 32'(exp_evt_q.size()), 32'd1);
                if (exp_evt_q.size() != 0) begin
                    ev = exp_evt_q.pop_front();
                    chk("event_kind", {30'h0, done, err}, {30'h0, ev});
                end
                if (done) chk("done_latency", 32'(cyc), 32'(tx_acc_cyc + 2));
                if (err)  chk("err_latency", 32'(cyc), 32'(last_pop_cyc + 1));
                $display("EVT %s cyc=%0d", done ? "done" : "err", cyc);
            end

            prev_rd  = rd;
            prev_m   = bus.m_stb_o;
            prev_tx  = txs;
            prev_evt = done || err;
        end
    end

    // Driver: loads RX bytes and pushes hand-computed expectations.
    initial begin
        int n;
        sys_rst_n = 1'b0;
        start = 1'b0;
        base_addr = 32'h0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;

        // One word: sum 11+22+33+44 = AA.
        rx_word(32'h1);
        rx_word(32'h4433_2211);
        exp_mem(32'h100, 32'h4433_2211);
        exp_tx_q.push_back(8'hAA);
        exp_evt_q.push_back(EV_DONE);
        launch(32'h100);
        finish_image("one_word");

        // Empty image.
        rx_word(32'h0);
        exp_tx_q.push_back(8'h00);
        exp_evt_q.push_back(EV_DONE);
        launch(32'h400);
        finish_image("empty");

        // Count above MAX_WORDS, then the all-ones count.
        rx_word(32'h5);
        exp_evt_q.push_back(EV_ERR);
        launch(32'h500);
        finish_image("too_big");
        rx_word(32'hFFFF_FFFF);
        exp_evt_q.push_back(EV_ERR);
        launch(32'h600);
        finish_image("all_ones");

        // Stalled handshakes, two words of FF: checksum 8*FF mod 256 = F8.
        mem_wait = 3;
        tx_wait = 5;
        rx_word(32'h2);
        rx_word(32'hFFFF_FFFF);
        rx_word(32'hFFFF_FFFF);
        exp_mem(32'h1000, 32'hFFFF_FFFF);
        exp_mem(32'h1004, 32'hFFFF_FFFF);
        exp_tx_q.push_back(8'hF8);
        exp_evt_q.push_back(EV_DONE);
        launch(32'h1000);
        finish_image("stalled");
        mem_wait = 0;
        tx_wait = 0;

        // Ten empty polls, then header and a word whose first byte follows more empty polls.
        rx_idle(10);
        rx_word(32'h1);
        rx_idle(3);
        rx_q.push_back(9'h1AB);
        rx(8'h01);
        rx(8'h02);
        rx(8'h03);
        exp_mem(32'h2000, 32'h0302_01AB);
        exp_tx_q.push_back(8'hB1);
        exp_evt_q.push_back(EV_DONE);
        launch(32'h2000);
        for (int i = 0; i < 20; i++) begin
            chk("poll_stb", 32'(bus.u_stb_o), 32'(i % 2 == 0));
            @(negedge sys_clk);
        end
        finish_image("polling");

        // Address wraps past 2^32: sum 1..8 = 0x24.
        rx_word(32'h2);
        rx_word(32'h0403_0201);
        rx_word(32'h0807_0605);
        exp_mem(32'hFFFF_FFFC, 32'h0403_0201);
        exp_mem(32'h0000_0000, 32'h0807_0605);
        exp_tx_q.push_back(8'h24);
        exp_evt_q.push_back(EV_DONE);
        launch(32'hFFFF_FFFC);
        finish_image("wrap");

        // Reset after six payload bytes, then a fresh image from a new base.
        rx_word(32'h2);
        rx_word(32'h4030_2010);
        rx(8'h50);
        rx(8'h60);
        exp_mem(32'h200, 32'h4030_2010);
        launch(32'h200);
        n = 0;
        while (rx_q.size() != 0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("abort_feed_timeout", 32'(rx_q.size()), 32'd0);
        repeat (6) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        rx_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chk("abort_mem_left", 32'(exp_adr_q.size()), 32'd0);
        rx_word(32'h1);
        rx_word(32'h0D0C_0B0A);
        exp_mem(32'h300, 32'h0D0C_0B0A);
        exp_tx_q.push_back(8'h2E);
        exp_evt_q.push_back(EV_DONE);
        launch(32'h300);
        finish_image("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Bus initiator that drives the UART CSR slave port to boot-load a program image over the serial line. It polls the UART receive register, assembles a little-endian word-count header and payload words, and writes each word to memory through a simple request/acknowledge master port. When the image is complete it writes an 8-bit checksum back through the UART transmit register. It sits between the UART CSR port and the instruction/data memory bus and is active only between `start` and `done`/`err`.

## Interface

Parameters:
- `UART_BASE`, 32'h0000_0000: UART CSR base address; the RX/TX data register is at offset 0, so bits [1:0] are always 2'b00.
- `MAX_WORDS`, 4096: largest accepted payload word count.

Ports:
- `sys_clk` in 1: single clock, rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level, sampled in IDLE only.
- `base_addr` in 32: first memory byte address; latched on start.
- `u_stb_o` out 1: UART strobe.
- `u_we_o` out 1: UART write enable.
- `u_adr_o` out 32: UART address.
- `u_dat_o` out 32: UART write data.
- `u_dat_i` in 32: UART read data (registered by slave): bit 8 = valid, [7:0] = byte.
- `u_ack_i` in 1: UART acknowledge; low on a TX write means the TX FIFO is full.
- `m_stb_o` out 1: memory write request.
- `m_adr_o` out 32: memory byte address.
- `m_dat_o` out 32: memory write data.
- `m_ack_i` in 1: memory acknowledge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the checksum write is accepted.
- `err` out 1: one-cycle pulse when the header count exceeds MAX_WORDS.

## Operation

- States: IDLE, RD_REQ, RD_WAIT, MEM_WR, TX_REQ, TX_GAP, FIN.
- IDLE, `start`=1: latch `base_addr` into the address register; clear byte index, word index and checksum; go to RD_REQ.
- RD_REQ: drive `u_stb_o`=1, `u_we_o`=0, `u_adr_o`=UART_BASE for exactly one cycle; go to RD_WAIT.
  - Strobe must drop between polls: the slave pops its RX FIFO only on the first cycle of a held read.
- RD_WAIT: all strobes low. Sample `u_dat_i`:
  - bit 8 = 0: return to RD_REQ.
  - bit 8 = 1: shift byte [7:0] into the assembly register at lane = byte index (lane 0 = bits [7:0]).
- Header phase (first 4 bytes): the assembled value is the word count N.
  - N > MAX_WORDS: pulse `err`, go to IDLE. No memory or TX traffic.
  - N = 0: go to TX_REQ.
  - Otherwise: continue to the payload.
- Payload phase: each byte is added to the 8-bit checksum (mod 256). After the 4th byte of a word, go to MEM_WR.
- MEM_WR: `m_stb_o`=1 with `m_adr_o`=current address and `m_dat_o`=assembled word, all held until `m_ack_i`=1 is sampled. Then:
  - Drop `m_stb_o`, add 4 to the address (wraps at 2^32), increment the word index.
  - If index == N, go to TX_REQ; else go to RD_REQ.
- TX_REQ: `u_stb_o`=1, `u_we_o`=1, `u_adr_o`=UART_BASE, `u_dat_o`={24'h0, checksum}, all held until `u_ack_i`=1; then go to TX_GAP.
- TX_GAP: one cycle with strobes low (the slave rejects back-to-back TX writes); go to FIN.
- FIN: pulse `done` for one cycle; go to IDLE.
- `start` is ignored while `busy`=1.

## Timing

- Reset: every output is 0 except `u_adr_o`=UART_BASE. State = IDLE; all counters and the checksum are cleared.
- Asserting `sys_rst_n` low mid-transfer aborts immediately. No `done` or `err` is issued; a partially assembled word is discarded.
- Poll period: 2 cycles (RD_REQ + RD_WAIT).
- Latency from the RD_WAIT that captures a word's 4th byte to `m_stb_o` high: 1 cycle.
- Handshakes: each ack is sampled on the rising edge. The strobe and payload are stable from assertion through the acknowledging edge and deassert on the following cycle. Zero-wait ack gives a 1-cycle strobe.
- Last `m_ack_i` to TX strobe: 1 cycle. Accepted TX to `done`: 2 cycles (TX_GAP, FIN).
- `err` is issued the cycle after the 4th header byte is captured.
- Word count comparisons use a 32-bit N, so N = 32'hFFFF_FFFF yields `err` for any MAX_WORDS < 2^32.

## Test plan

- Base 0x100; RX bytes 01 00 00 00 11 22 33 44 -> one memory write, adr 0x100, data 0x44332211; TX write data 0x000000AA; `done` pulses once; `busy` returns to 0.
- Header 00 00 00 00 -> no `m_stb_o`; TX data 0x00; `done` pulses.
- MAX_WORDS=4; header 05 00 00 00 -> `err` pulse one cycle after the 4th byte; no memory or TX strobes; back to IDLE.
- N=2 with bytes all 0xFF -> writes 0xFFFFFFFF at base and base+4; checksum 0xF8 (8×0xFF mod 256). Hold `m_ack_i` low 3 cycles and `u_ack_i` low 5 cycles -> strobe, address and data stay stable throughout; exactly one TX gap cycle before `done`.
- Valid bit 0 for 10 polls -> `u_stb_o` alternates 1,0 for 20 cycles; no byte captured. Then valid 0x1AB -> byte 0xAB captured.
- Drop `sys_rst_n` after 6 payload bytes -> all outputs at reset values on the same cycle. A following `start` with a fresh image loads correctly from the new `base_addr`.
